uart_rx_fsm: RTL and testbench

- Control stage of the UART receiver. It detects the start of a frame and tracks oversampling edges and bit position.
- It drives the enables of the data sampler, the deserializer and the start/parity/stop checkers.
- It consumes the one-cycle error strobes those checkers produce, including the stop checker's stp_err, and issues data_valid for each clean frame.

---
 rtl/uart_rx_fsm.sv | 159 +++++++++++++++
 tb/tb_uart_rx_fsm.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fsm.sv
// UART receiver control FSM: frames the serial line into start/data/parity/stop
// bits, times the checker enables on the oversample grid and reports clean frames.
module uart_rx_fsm #(
    parameter int DATA_WIDTH = 8
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       RX_IN,
    input  logic [5:0] Prescale,
    input  logic       PAR_EN,
    input  logic       strt_glitch,
    input  logic       par_err,
    input  logic       stp_err,
    output logic [5:0] edge_cnt,
    output logic       dat_samp_en,
    output logic       strt_chk_en,
    output logic       par_chk_en,
    output logic       stp_chk_en,
    output logic       deser_en,
    output logic       data_valid,
    output logic       par_err_flag,
    output logic       stp_err_flag,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    localparam logic [2:0] LAST_BIT = 3'(DATA_WIDTH - 1);

    state_t     state_r;
    logic [5:0] prescale_r;
    logic       par_en_r;
    logic [2:0] bit_cnt_r;

    logic [5:0] chk_pt_s;
    logic [5:0] err_pt_s;
    logic [5:0] end_pt_s;
    logic [5:0] next_edge_s;
    logic       at_chk_s;
    logic       at_err_s;
    logic       at_end_s;

    // Bit-timing points derived from the prescale captured at frame start
    always_comb begin
        chk_pt_s    = {1'b0, prescale_r[5:1]} + 6'd2;
        err_pt_s    = {1'b0, prescale_r[5:1]} + 6'd3;
        end_pt_s    = prescale_r - 6'd1;
        at_chk_s    = (edge_cnt == chk_pt_s);
        at_err_s    = (edge_cnt == err_pt_s);
        at_end_s    = (edge_cnt == end_pt_s);
        next_edge_s = at_end_s ? 6'd0 : (edge_cnt + 6'd1);
    end

    // Frame sequencer with registered counters, flags and data_valid
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_r      <= IDLE;
            edge_cnt     <= 6'd0;
            bit_cnt_r    <= 3'd0;
            prescale_r   <= 6'd0;
            par_en_r     <= 1'b0;
            data_valid   <= 1'b0;
            par_err_flag <= 1'b0;
            stp_err_flag <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            case (state_r)
                IDLE: begin
                    edge_cnt  <= 6'd0;
                    bit_cnt_r <= 3'd0;
                    if (!RX_IN) begin
                        state_r      <= START;
                        prescale_r   <= Prescale;
                        par_en_r     <= PAR_EN;
                        par_err_flag <= 1'b0;
                        stp_err_flag <= 1'b0;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                START: begin
                    // A glitch verdict wins even when ERR coincides with END (P=8)
                    if (at_err_s && strt_glitch) begin
                        state_r  <= IDLE;
                        edge_cnt <= 6'd0;
                    end else if (at_end_s) begin
                        state_r   <= DATA;
                        edge_cnt  <= 6'd0;
                        bit_cnt_r <= 3'd0;
                    end else begin
                        edge_cnt <= next_edge_s;
                    end
                end
                DATA: begin
                    edge_cnt <= next_edge_s;
                    if (at_end_s) begin
                        if (bit_cnt_r == LAST_BIT) begin
                            state_r <= par_en_r ? PARITY : STOP;
                        end else begin
                            bit_cnt_r <= bit_cnt_r + 3'd1;
                        end
                    end else begin
                        state_r <= DATA;
                    end
                end
                PARITY: begin
                    edge_cnt <= next_edge_s;
                    if (at_err_s && par_err) begin
                        par_err_flag <= 1'b1;
                    end else begin
                        par_err_flag <= par_err_flag;
                    end
                    if (at_end_s) begin
                        state_r <= STOP;
                    end else begin
                        state_r <= PARITY;
                    end
                end
                STOP: begin
                    edge_cnt <= next_edge_s;
                    if (at_err_s && stp_err) begin
                        stp_err_flag <= 1'b1;
                    end else begin
                        stp_err_flag <= stp_err_flag;
                    end
                    // Include a stop error landing on the final edge itself
                    if (at_end_s) begin
                        state_r    <= IDLE;
                        data_valid <= ~(par_err_flag | stp_err_flag | (at_err_s & stp_err));
                    end else begin
                        state_r <= STOP;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    edge_cnt  <= 6'd0;
                    bit_cnt_r <= 3'd0;
                end
            endcase
        end
    end

    // Enable decode straight off registered state so enables add no latency
    always_comb begin
        busy        = (state_r != IDLE);
        dat_samp_en = (state_r != IDLE);
        strt_chk_en = (state_r == START)  && at_chk_s;
        deser_en    = (state_r == DATA)   && at_chk_s;
        par_chk_en  = (state_r == PARITY) && at_chk_s;
        stp_chk_en  = (state_r == STOP)   && at_chk_s;
    end

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Directed bench for uart_rx_fsm: table of whole-frame scenarios with hand-computed
// pulse positions, plus reset-abort and back-to-back/prescale-change sequences.
module tb_uart_rx_fsm;

    logic       Clk;
    logic       Rst;
    logic       RX_IN;
    logic [5:0] Prescale;
    logic       PAR_EN;
    logic       strt_glitch;
    logic       par_err;
    logic       stp_err;
    logic [5:0] edge_cnt;
    logic       dat_samp_en;
    logic       strt_chk_en;
    logic       par_chk_en;
    logic       stp_chk_en;
    logic       deser_en;
    logic       data_valid;
    logic       par_err_flag;
    logic       stp_err_flag;
    logic       busy;

    int checks_r = 0;
    int errs_r   = 0;

    uart_rx_fsm #(.DATA_WIDTH(8)) dut (
        .Clk(Clk), .Rst(Rst), .RX_IN(RX_IN), .Prescale(Prescale), .PAR_EN(PAR_EN),
        .strt_glitch(strt_glitch), .par_err(par_err), .stp_err(stp_err),
        .edge_cnt(edge_cnt), .dat_samp_en(dat_samp_en), .strt_chk_en(strt_chk_en),
        .par_chk_en(par_chk_en), .stp_chk_en(stp_chk_en), .deser_en(deser_en),
        .data_valid(data_valid), .par_err_flag(par_err_flag),
        .stp_err_flag(stp_err_flag), .busy(busy)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Cycle numbers are relative to the first START cycle (cycle 0); -1 means none.
    typedef struct {
        int presc;
        int par_en;
        int glitch_cyc;
        int par_cyc;
        int stp_cyc;
        int deser_n;
        int deser_first;
        int deser_last;
        int strt_n;
        int par_n;
        int stp_n;
        int stp_chk_cyc;
        int dv_n;
        int dv_cyc;
        int idle_cyc;
        int par_flag;
        int stp_flag;
        int flag_rise;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input int act, input int exp);
        checks_r++;
        if (act != exp) begin
            errs_r++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int all_outs();
        return int'({edge_cnt, dat_samp_en, strt_chk_en, par_chk_en, stp_chk_en,
                     deser_en, data_valid, par_err_flag, stp_err_flag, busy});
    endfunction

    task automatic run_frame(input int idx, input vec_t v);
        int deser_n = 0, deser_first = -1, deser_last = -1;
        int strt_n = 0, par_n = 0, stp_n = 0, stp_cyc = -1;
        int dv_n = 0, dv_cyc = -1, idle_obs = -1, rise = -1;
        int edge_last = -1, edge_idle = -1;
        @(negedge Clk);
        RX_IN    = 1'b0;
        Prescale = 6'(v.presc);
        PAR_EN   = (v.par_en != 0);
        @(posedge Clk);
        for (int c = 0; c <= v.idle_cyc + 3; c++) begin
            @(negedge Clk);
            RX_IN       = 1'b1;
            strt_glitch = (c == v.glitch_cyc);
            par_err     = (c == v.par_cyc);
            stp_err     = (c == v.stp_cyc);
            if (deser_en) begin
                deser_n++;
                if (deser_first < 0) deser_first = c;
                deser_last = c;
            end
            if (strt_chk_en) strt_n++;
            if (par_chk_en) par_n++;
            if (stp_chk_en) begin
                stp_n++;
                if (stp_cyc < 0) stp_cyc = c;
            end
            if (data_valid) begin
                dv_n++;
                if (dv_cyc < 0) dv_cyc = c;
            end
            if (!busy && idle_obs < 0) idle_obs = c;
            if ((par_err_flag || stp_err_flag) && rise < 0) rise = c;
            if (c == v.idle_cyc - 1) edge_last = int'(edge_cnt);
            if (c == v.idle_cyc) edge_idle = int'(edge_cnt);
        end
        strt_glitch = 1'b0;
        par_err     = 1'b0;
        stp_err     = 1'b0;
        chk($sformatf("v%0d_deser_n", idx), deser_n, v.deser_n);
        chk($sformatf("v%0d_deser_first", idx), deser_first, v.deser_first);
        chk($sformatf("v%0d_deser_last", idx), deser_last, v.deser_last);
        chk($sformatf("v%0d_strt_n", idx), strt_n, v.strt_n);
        chk($sformatf("v%0d_par_n", idx), par_n, v.par_n);
        chk($sformatf("v%0d_stp_n", idx), stp_n, v.stp_n);
        chk($sformatf("v%0d_stp_chk_cyc", idx), stp_cyc, v.stp_chk_cyc);
        chk($sformatf("v%0d_dv_n", idx), dv_n, v.dv_n);
        chk($sformatf("v%0d_dv_cyc", idx), dv_cyc, v.dv_cyc);
        chk($sformatf("v%0d_idle_cyc", idx), idle_obs, v.idle_cyc);
        chk($sformatf("v%0d_par_flag", idx), int'(par_err_flag), v.par_flag);
        chk($sformatf("v%0d_stp_flag", idx), int'(stp_err_flag), v.stp_flag);
        chk($sformatf("v%0d_flag_rise", idx), rise, v.flag_rise);
        chk($sformatf("v%0d_edge_end", idx), edge_last, v.presc - 1);
        chk($sformatf("v%0d_edge_idle", idx), edge_idle, 0);
    endtask

    initial begin
        int dv_n, dv1, dv2, first2, second1;
        //           P  PE glit par  stp  dN first last st pa sp spc  dvN dvc  idle pf sf rise
        vecs[0] = '{ 8, 0, -1, -1,  -1,  8, 14,  70,  1, 0, 1, 78,  1,  80,  80, 0, 0, -1};
        vecs[1] = '{16, 1, -1, 155, -1,  8, 26,  138, 1, 1, 1, 170, 0,  -1,  176, 1, 0, 156};
        vecs[2] = '{16, 0, -1, -1,  155, 8, 26,  138, 1, 0, 1, 154, 0,  -1,  160, 0, 1, 156};
        vecs[3] = '{ 8, 0,  7, -1,  -1,  0, -1,  -1,  1, 0, 0, -1,  0,  -1,  8,   0, 0, -1};
        vecs[4] = '{ 8, 0, -1, -1,  -1,  8, 14,  70,  1, 0, 1, 78,  1,  80,  80, 0, 0, -1};
        vecs[5] = '{32, 1, -1, -1,  -1,  8, 50,  274, 1, 1, 1, 338, 1,  352, 352, 0, 0, -1};
        vecs[6] = '{ 8, 0, -1, -1,  79,  8, 14,  70,  1, 0, 1, 78,  0,  -1,  80,  0, 1, 80};

        Rst         = 1'b0;
        RX_IN       = 1'b1;
        Prescale    = 6'd8;
        PAR_EN      = 1'b0;
        strt_glitch = 1'b0;
        par_err     = 1'b0;
        stp_err     = 1'b0;
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        chk("reset_outs", all_outs(), 0);
        Rst = 1'b1;
        repeat (3) @(negedge Clk);
        chk("idle_outs", all_outs(), 0);

        for (int i = 0; i < 7; i++) begin
            run_frame(i, vecs[i]);
        end

        // Reset in the middle of data bit 3 (cycles 32..39 at P=8)
        @(negedge Clk);
        RX_IN    = 1'b0;
        Prescale = 6'd8;
        PAR_EN   = 1'b0;
        @(posedge Clk);
        for (int c = 0; c <= 35; c++) begin
            @(negedge Clk);
            RX_IN = 1'b1;
        end
        chk("pre_abort_busy", int'(busy), 1);
        Rst = 1'b0;
        #1;
        chk("abort_outs", all_outs(), 0);
        @(negedge Clk);
        Rst = 1'b1;
        repeat (2) @(negedge Clk);
        chk("post_abort_outs", all_outs(), 0);
        run_frame(7, vecs[0]);

        // Back-to-back frames, Prescale changed to 8 during the P=32 frame
        dv_n = 0; dv1 = -1; dv2 = -1; first2 = -1; second1 = -1;
        @(negedge Clk);
        RX_IN    = 1'b0;
        Prescale = 6'd32;
        PAR_EN   = 1'b0;
        @(posedge Clk);
        for (int c = 0; c <= 410; c++) begin
            @(negedge Clk);
            RX_IN = (c == 320) ? 1'b0 : 1'b1;
            if (c == 100) Prescale = 6'd8;
            if (data_valid) begin
                dv_n++;
                if (dv1 < 0) dv1 = c;
                else if (dv2 < 0) dv2 = c;
            end
            if (deser_en && c < 320 && second1 < 0 && c > 50) second1 = c;
            if (deser_en && c > 321 && first2 < 0) first2 = c;
        end
        chk("b2b_dv_n", dv_n, 2);
        chk("b2b_dv1", dv1, 320);
        chk("b2b_dv2", dv2, 401);
        chk("b2b_f1_deser2", second1, 82);
        chk("b2b_f2_deser1", first2, 335);
        chk("b2b_final_busy", int'(busy), 0);

        $display("Result: errors=%0d of %0d checks", errs_r, checks_r);
        $finish;
    end

endmodule
